// File: rtl/useq_pkg.sv
// Shared definitions for the useq microsequencer and its boot controller.
package useq_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_SYNC = 3'd0,
    ST_LEN       = 3'd1,
    ST_BASE      = 3'd2,
    ST_PAYLOAD   = 3'd3,
    ST_CKSUM     = 3'd4,
    ST_RELEASE   = 3'd5,
    ST_RUN       = 3'd6,
    ST_ERROR     = 3'd7
  } boot_state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_CKSUM   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/useq_boot_ctrl_if.sv
// Byte-stream handshake carrying the program image into useq_boot_ctrl.
interface useq_boot_ctrl_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/useq_boot_ctrl.sv
// Loads a framed program image into the useq program RAM, checks its
// checksum and releases the core once a valid image is in place.
module useq_boot_ctrl
  import useq_pkg::*;
#(
  parameter int unsigned RST_HOLD  = 4,
  parameter int unsigned TIMEOUT   = 1024,
  parameter logic [7:0]  SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
  input  logic                   clk,
  input  logic                   rst_n,
  useq_boot_ctrl_if.slave        s,
  input  logic                   boot_req,
  input  logic [7:0]             core_addr,
  output logic                   core_rst_n,
  output logic [7:0]             ram_addr,
  output logic                   ram_we,
  output logic [7:0]             ram_wdata,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             err_code
);

  localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  boot_state_e       state_q, state_d;
  logic [8:0]        cnt_q, cnt_d;
  logic [7:0]        ptr_q, ptr_d;
  logic [7:0]        sum_q, sum_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [7:0]        hold_q, hold_d;
  logic [1:0]        err_q, err_d;
  logic              we_q, we_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        waddr_q, waddr_d;

  logic       s_ready_s;
  logic       in_frame_s;
  logic       xfer_s;
  logic       timeout_s;
  logic [7:0] cksum_s;

  assign in_frame_s = (state_q == ST_LEN) || (state_q == ST_BASE) ||
                      (state_q == ST_PAYLOAD) || (state_q == ST_CKSUM);
  assign s_ready_s  = in_frame_s || (state_q == ST_WAIT_SYNC);
  assign xfer_s     = s.s_valid & s_ready_s;
  assign cksum_s    = sum_q + s.s_data;
  // A byte arriving on the expiry cycle keeps the frame alive.
  assign timeout_s  = (TIMEOUT != 0) && in_frame_s && !xfer_s &&
                      (idle_q == IDLE_W'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    sum_d   = sum_q;
    idle_d  = idle_q;
    hold_d  = hold_q;
    err_d   = err_q;
    we_d    = 1'b0;
    wdata_d = wdata_q;
    waddr_d = waddr_q;

    if (boot_req) begin
      state_d = ST_WAIT_SYNC;
      err_d   = ERR_NONE;
      idle_d  = '0;
      hold_d  = 8'd0;
    end else begin
      if (in_frame_s && !xfer_s) begin
        idle_d = idle_q + 1'b1;
      end else begin
        idle_d = '0;
      end

      case (state_q)
        ST_WAIT_SYNC: begin
          if (xfer_s && (s.s_data == SYNC_BYTE)) begin
            state_d = ST_LEN;
          end else begin
            state_d = ST_WAIT_SYNC;
          end
        end
        ST_LEN: begin
          if (xfer_s) begin
            cnt_d   = (s.s_data == 8'd0) ? 9'd256 : {1'b0, s.s_data};
            sum_d   = s.s_data;
            state_d = ST_BASE;
          end else begin
            state_d = ST_LEN;
          end
        end
        ST_BASE: begin
          if (xfer_s) begin
            ptr_d   = s.s_data;
            sum_d   = cksum_s;
            state_d = ST_PAYLOAD;
          end else begin
            state_d = ST_BASE;
          end
        end
        ST_PAYLOAD: begin
          if (xfer_s) begin
            we_d    = 1'b1;
            waddr_d = ptr_q;
            wdata_d = s.s_data;
            ptr_d   = ptr_q + 8'd1;
            sum_d   = cksum_s;
            cnt_d   = cnt_q - 9'd1;
            state_d = (cnt_q == 9'd1) ? ST_CKSUM : ST_PAYLOAD;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end
        ST_CKSUM: begin
          if (xfer_s && (cksum_s == 8'd0)) begin
            hold_d  = 8'd0;
            state_d = ST_RELEASE;
          end else if (xfer_s) begin
            err_d   = ERR_CKSUM;
            state_d = ST_ERROR;
          end else begin
            state_d = ST_CKSUM;
          end
        end
        ST_RELEASE: begin
          if (hold_q == 8'(RST_HOLD - 1)) begin
            state_d = ST_RUN;
          end else begin
            hold_d = hold_q + 8'd1;
          end
        end
        ST_RUN:   state_d = ST_RUN;
        ST_ERROR: state_d = ST_ERROR;
        default:  state_d = ST_WAIT_SYNC;
      endcase

      if (timeout_s) begin
        err_d   = ERR_TIMEOUT;
        state_d = ST_ERROR;
      end else begin
        err_d = err_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_WAIT_SYNC;
      cnt_q   <= 9'd0;
      ptr_q   <= 8'd0;
      sum_q   <= 8'd0;
      idle_q  <= '0;
      hold_q  <= 8'd0;
      err_q   <= ERR_NONE;
      we_q    <= 1'b0;
      wdata_q <= 8'd0;
      waddr_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      sum_q   <= sum_d;
      idle_q  <= idle_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
    end
  end

  // Core only runs in RUN, so it never contends with a pending write.
  assign ram_addr   = we_q ? waddr_q : core_addr;
  assign ram_we     = we_q;
  assign ram_wdata  = wdata_q;
  assign s.s_ready  = s_ready_s;
  assign busy       = in_frame_s;
  assign done       = (state_q == ST_RUN);
  assign core_rst_n = (state_q == ST_RUN);
  assign err_code   = err_q;

endmodule

// File: tb/tb_useq_boot_ctrl.sv
// Directed self-checking bench for useq_boot_ctrl with a behavioural 256x8 RAM.
module tb_useq_boot_ctrl;
  import useq_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       boot_req = 1'b0;
  logic [7:0] core_addr = 8'h00;
  logic       core_rst_n, ram_we, busy, done;
  logic [7:0] ram_addr, ram_wdata;
  logic [1:0] err_code;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [256] = '{default: 8'h00};
  logic [7:0] tx_q [$];

  useq_boot_ctrl_if s_if();

  useq_boot_ctrl #(.RST_HOLD(4), .TIMEOUT(16), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .s(s_if), .boot_req(boot_req), .core_addr(core_addr),
    .core_rst_n(core_rst_n), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .busy(busy), .done(done), .err_code(err_code)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends tx_q back-to-back with s_valid held high; every byte must be accepted.
  task automatic send_bytes();
    logic [7:0] b;
    s_if.s_valid = 1'b1;
    while (tx_q.size() > 0) begin
      b = tx_q.pop_front();
      s_if.s_data = b;
      checks++;
      if (s_if.s_ready !== 1'b1) begin failures++; $display("FAIL stream_ready byte=%h: s_ready=%b required 1", b, s_if.s_ready); end
      step();
    end
    s_if.s_valid = 1'b0;
  endtask

  task automatic do_boot();
    boot_req = 1'b1;
    step();
    boot_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    checks++; if (s_if.s_ready !== 1'b1) begin failures++; $display("FAIL reset_s_ready: got %b required 1", s_if.s_ready); end
    checks++; if (core_rst_n !== 1'b0) begin failures++; $display("FAIL reset_core_rst_n: got %b required 0", core_rst_n); end
    checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL reset_ram_we: got %b required 0", ram_we); end
    checks++; if (ram_wdata !== 8'h00) begin failures++; $display("FAIL reset_ram_wdata: got %h required 00", ram_wdata); end
    checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL reset_busy_done: got %b required 00", {busy, done}); end
    checks++; if (err_code !== 2'b00) begin failures++; $display("FAIL reset_err: got %b required 00", err_code); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_good_frame();
    tx_q = '{8'hA5, 8'h03, 8'h10, 8'h11, 8'h22, 8'h33, 8'h87};
    send_bytes();
    checks++; if ({s_if.s_ready, core_rst_n, done, busy} !== 4'b0000) begin failures++; $display("FAIL good_release: ready/rst/done/busy=%b required 0000", {s_if.s_ready, core_rst_n, done, busy}); end
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k < 4) begin
        checks++; if (core_rst_n !== 1'b0) begin failures++; $display("FAIL good_hold k=%0d: core_rst_n=%b required 0", k, core_rst_n); end
      end
    end
    checks++; if ({core_rst_n, done} !== 2'b11) begin failures++; $display("FAIL good_run: rst/done=%b required 11", {core_rst_n, done}); end
    checks++; if (err_code !== ERR_NONE) begin failures++; $display("FAIL good_err: got %b required 00", err_code); end
    checks++; if ({mem[8'h10], mem[8'h11], mem[8'h12]} !== 24'h112233) begin failures++; $display("FAIL good_ram: got %h required 112233", {mem[8'h10], mem[8'h11], mem[8'h12]}); end
    core_addr = 8'h12;
    #1;
    checks++; if (ram_addr !== 8'h12) begin failures++; $display("FAIL fetch_addr_mux: got %h required 12", ram_addr); end
  endtask

  task automatic test_boot_in_run();
    do_boot();
    checks++; if ({core_rst_n, busy, done, s_if.s_ready} !== 4'b0001) begin failures++; $display("FAIL boot_in_run: rst/busy/done/ready=%b required 0001", {core_rst_n, busy, done, s_if.s_ready}); end
  endtask

  task automatic test_wrap();
    tx_q = '{8'hA5, 8'h02, 8'hFF, 8'hAA, 8'hBB, 8'h9A};
    send_bytes();
    repeat (4) step();
    checks++; if ({core_rst_n, done} !== 2'b11) begin failures++; $display("FAIL wrap_run: rst/done=%b required 11", {core_rst_n, done}); end
    checks++; if ({mem[8'hFF], mem[8'h00]} !== 16'hAABB) begin failures++; $display("FAIL wrap_ram: got %h required AABB", {mem[8'hFF], mem[8'h00]}); end
    do_boot();
  endtask

  task automatic test_bad_cksum();
    tx_q = '{8'hA5, 8'h03, 8'h10, 8'h11, 8'h22, 8'h33, 8'h88};
    send_bytes();
    checks++; if (err_code !== ERR_CKSUM) begin failures++; $display("FAIL bad_err: got %b required 01", err_code); end
    checks++; if ({s_if.s_ready, busy} !== 2'b00) begin failures++; $display("FAIL bad_ready: ready/busy=%b required 00", {s_if.s_ready, busy}); end
    repeat (6) step();
    checks++; if ({core_rst_n, done, err_code} !== 4'b0001) begin failures++; $display("FAIL bad_stays: rst/done/err=%b required 0001", {core_rst_n, done, err_code}); end
    do_boot();
    checks++; if ({err_code, s_if.s_ready} !== 3'b001) begin failures++; $display("FAIL bad_boot: err/ready=%b required 001", {err_code, s_if.s_ready}); end
  endtask

  task automatic test_timeout();
    tx_q = '{8'hA5, 8'h02, 8'h00, 8'h11};
    send_bytes();
    repeat (15) step();
    checks++; if ({busy, err_code} !== 3'b100) begin failures++; $display("FAIL timeout_early: busy/err=%b required 100", {busy, err_code}); end
    step();
    checks++; if (err_code !== ERR_TIMEOUT) begin failures++; $display("FAIL timeout_err: got %b required 10", err_code); end
    checks++; if ({busy, s_if.s_ready, core_rst_n} !== 3'b000) begin failures++; $display("FAIL timeout_state: busy/ready/rst=%b required 000", {busy, s_if.s_ready, core_rst_n}); end
    do_boot();
    checks++; if (err_code !== ERR_NONE) begin failures++; $display("FAIL timeout_boot: got %b required 00", err_code); end
  endtask

  task automatic test_transfer_beats_timeout();
    tx_q = '{8'hA5, 8'h02, 8'h00, 8'h11};
    send_bytes();
    repeat (15) step();
    tx_q = '{8'h22, 8'hCB};
    send_bytes();
    checks++; if ({err_code, s_if.s_ready} !== 3'b000) begin failures++; $display("FAIL late_xfer: err/ready=%b required 000", {err_code, s_if.s_ready}); end
    repeat (4) step();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL late_xfer_done: got %b required 1", done); end
    checks++; if ({mem[8'h00], mem[8'h01]} !== 16'h1122) begin failures++; $display("FAIL late_xfer_ram: got %h required 1122", {mem[8'h00], mem[8'h01]}); end
    do_boot();
  endtask

  task automatic test_garbage_len0();
    int bad;
    tx_q = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h00};
    for (int i = 0; i < 256; i++) tx_q.push_back(8'(i));
    tx_q.push_back(8'h80);
    send_bytes();
    checks++; if ({s_if.s_ready, err_code} !== 3'b000) begin failures++; $display("FAIL len0_release: ready/err=%b required 000", {s_if.s_ready, err_code}); end
    repeat (4) step();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL len0_done: got %b required 1", done); end
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== 8'(i)) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL len0_ram: %0d entries differ, required 0", bad); end
    do_boot();
  endtask

  task automatic test_boot_mid_payload();
    tx_q = '{8'hA5, 8'h04, 8'h40, 8'h01, 8'h02};
    send_bytes();
    s_if.s_valid = 1'b1;
    s_if.s_data  = 8'h03;
    boot_req     = 1'b1;
    step();
    boot_req     = 1'b0;
    s_if.s_valid = 1'b0;
    checks++; if ({core_rst_n, busy, s_if.s_ready, ram_we} !== 4'b0010) begin failures++; $display("FAIL boot_mid: rst/busy/ready/we=%b required 0010", {core_rst_n, busy, s_if.s_ready, ram_we}); end
    step();
    checks++; if ({mem[8'h40], mem[8'h41], mem[8'h42]} !== 24'h010242) begin failures++; $display("FAIL boot_mid_ram: got %h required 010242", {mem[8'h40], mem[8'h41], mem[8'h42]}); end
  endtask

  task automatic test_rst_mid_frame();
    tx_q = '{8'hA5, 8'h03, 8'h20, 8'h55};
    send_bytes();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++; if ({s_if.s_ready, busy, ram_we, err_code} !== 5'b10000) begin failures++; $display("FAIL rst_mid_state: ready/busy/we/err=%b required 10000", {s_if.s_ready, busy, ram_we, err_code}); end
    checks++; if (ram_wdata !== 8'h00) begin failures++; $display("FAIL rst_mid_wdata: got %h required 00", ram_wdata); end
    checks++; if (mem[8'h20] !== 8'h55) begin failures++; $display("FAIL rst_mid_ram: got %h required 55", mem[8'h20]); end
  endtask

  initial begin
    s_if.s_valid = 1'b0;
    s_if.s_data  = 8'h00;
    test_reset();
    test_good_frame();
    test_boot_in_run();
    test_wrap();
    test_bad_cksum();
    test_timeout();
    test_transfer_beats_timeout();
    test_garbage_len0();
    test_boot_mid_payload();
    test_rst_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/useq_boot_ctrl.md
# useq_boot_ctrl

Boot and program-memory controller for the `useq` microsequencer. It receives a framed program image over a byte stream and writes it into the 256×8 program RAM shared with the core. It verifies the frame checksum, holds the core in reset until a valid image is loaded, and then hands the RAM address port to the core for instruction fetch.

## Interface
- `RST_HOLD`, default 4: cycles `core_rst_n` stays low after a good checksum (1..255).
- `TIMEOUT`, default 1024: maximum idle cycles between bytes inside a frame; 0 disables the timeout.
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `s_data`  in  8  stream byte.
- `s_valid`  in  1  stream byte valid.
- `s_ready`  out  1  controller accepts a byte; the transfer occurs when `s_valid & s_ready` at a rising edge.
- `boot_req`  in  1  one-cycle reload request.
- `core_addr`  in  8  core `mem_addr`.
- `core_rst_n`  out  1  reset to the core, active-low.
- `ram_addr`  out  8  RAM address: the write address when `ram_we` is high, otherwise `core_addr`.
- `ram_we`  out  1  RAM write strobe.
- `ram_wdata`  out  8  RAM write data.
- `busy`  out  1  a frame is in progress (states LEN..CKSUM).
- `done`  out  1  state RUN.
- `err_code`  out  2  00 none, 01 checksum, 10 timeout.

## Operation
- Frame format: SYNC, LEN, BASE, LEN payload bytes, CKSUM.
  - LEN=0 means 256 payload bytes.
  - The frame is valid when (LEN + BASE + payload + CKSUM) mod 256 == 0.
- States:
  - WAIT_SYNC: `s_ready`=1. Non-SYNC bytes are discarded. SYNC → LEN.
  - LEN: latch the count, seed the running sum → BASE.
  - BASE: latch the write pointer, add to the sum → PAYLOAD.
  - PAYLOAD: each accepted byte is written at the pointer. Pointer increments modulo 256 (wraps FF→00). After the last byte → CKSUM.
  - CKSUM: sum == 0 → RELEASE; otherwise → ERROR with `err_code`=01.
  - RELEASE: `s_ready`=0, count RST_HOLD cycles → RUN.
  - RUN: `core_rst_n`=1, `done`=1, `s_ready`=0.
  - ERROR: `s_ready`=0; the core stays in reset.
- Payload is written before verification. A bad checksum leaves the RAM dirty but keeps the core in reset.
- Timeout:
  - The idle counter runs in LEN..CKSUM and clears on every transfer.
  - Reaching TIMEOUT → ERROR with `err_code`=10.
  - A transfer in the same cycle as the timeout wins.
- `boot_req`:
  - Highest priority. From any state, the next state is WAIT_SYNC, `core_rst_n`=0, and `err_code` is cleared.
  - A byte transferred in the same cycle is discarded.
- `core_rst_n` is low in every state except RUN. The core therefore never fetches while `ram_we` is active, so no arbitration stall is needed.

## Timing
- Reset values (state after the first edge with `rst_n` low):
  - State WAIT_SYNC.
  - `s_ready`=1, derived from state.
  - `core_rst_n`=0, `ram_we`=0, `ram_wdata`=0.
  - `busy`=0, `done`=0, `err_code`=00.
  - Internal counters are 0.
- `s_ready`, `busy` and `done` decode from the registered state. `ram_we`, `ram_wdata` and the write address are registered.
- Payload transfer at edge t: `ram_we`=1 with address/data valid for one cycle after t. The RAM captures at edge t+1.
- Throughput: one byte per cycle in every accepting state. No bubbles between payload bytes.
- CKSUM transfer at edge t: state RELEASE after t. `core_rst_n` rises after edge t+RST_HOLD, and `done` rises on the same edge.
- `ram_addr` is a combinational mux and adds no cycles to the core's fetch path.
- `rst_n` low mid-frame: the frame is abandoned and the block returns to reset values; RAM contents are untouched.

## Structure
- Shared package `useq_pkg`:
  - state enum.
  - `err_code` constants (`ERR_NONE`, `ERR_CKSUM`, `ERR_TIMEOUT`).
  - default `SYNC_BYTE`.
- Single flat module; no sub-module is warranted.
- The RAM is instantiated by the parent alongside `useq`.

## Test plan
- Good frame: A5 03 10 11 22 33 87 → writes 11@10, 22@11, 33@12. `core_rst_n` rises RST_HOLD cycles after the 87 byte; `done`=1, `err_code`=00.
- Address wrap: A5 02 FF AA BB 9A → AA@FF, BB@00; RUN.
- Bad checksum: A5 03 10 11 22 33 88 → ERROR, `err_code`=01, `core_rst_n` stays 0, `s_ready`=0. `boot_req` then returns the block to WAIT_SYNC with `err_code`=00.
- Timeout: with TIMEOUT=16, send A5 02 00 11 then idle 16 cycles → ERROR, `err_code`=10. Transfer on cycle 16 instead → no error.
- Garbage and LEN=0: send 00 FF 5A, then A5 00 00 with 256 bytes i, then cksum → the first three bytes are ignored and RAM[i]=i for all i. With `s_valid` held high, there is one transfer per cycle and no bubbles.
- `boot_req` in RUN and mid-PAYLOAD → `core_rst_n`=0 and `busy`=0 next cycle. A byte transferred with `boot_req` is not written.
